// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store.
// One access every three cycles: IDLE (arbitrate/latch), ACCESS (drive memory), RESP (respond).
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned AW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic          d_signed,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic          d_err,
    output logic [31:0]   d_rdata,
    output logic          mem_ifetch,
    output logic          mem_read,
    output logic          mem_write,
    output logic [1:0]    mem_size,
    output logic          mem_signed,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state, state_nxt;
    logic [3:0]    streak;
    logic          own_d;
    logic          lat_we;
    logic          lat_signed;
    logic          lat_err;
    logic [1:0]    lat_size;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic          any_req;
    logic          pick_if;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return a != 2'b00;
            2'b01:   return a[0];
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign any_req = if_req | d_req;
    // D has priority unless fetch has been waiting through a full streak.
    assign pick_if = if_req && (!d_req || streak == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_ifetch = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = '0;
        mem_signed = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = state != IDLE;
        if (state == ACCESS && !rst) begin
            mem_ifetch = !own_d;
            mem_read   = own_d && !lat_we && !lat_err;
            mem_write  = own_d &&  lat_we && !lat_err;
            mem_size   = lat_size;
            mem_signed = lat_signed;
            mem_addr   = lat_addr;
            mem_wdata  = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak     <= '0;
            own_d      <= 1'b0;
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_err    <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    if (pick_if) begin
                        own_d      <= 1'b0;
                        lat_we     <= 1'b0;
                        lat_signed <= 1'b0;
                        lat_err    <= 1'b0;
                        lat_size   <= '0;
                        lat_addr   <= if_addr;
                        lat_wdata  <= '0;
                        if_gnt     <= 1'b1;
                        streak     <= '0;
                    end else begin
                        own_d      <= 1'b1;
                        lat_we     <= d_we;
                        lat_signed <= d_signed;
                        lat_err    <= misaligned(d_size, d_addr[1:0]);
                        lat_size   <= d_size;
                        lat_addr   <= d_addr;
                        lat_wdata  <= d_wdata;
                        d_gnt      <= 1'b1;
                        if (!if_req)              streak <= '0;
                        else if (streak != LIMIT) streak <= streak + 4'd1;
                    end
                end
                ACCESS: begin
                    if (own_d) begin
                        d_done  <= 1'b1;
                        d_err   <= lat_err;
                        d_rdata <= (!lat_we && !lat_err) ? mem_rdata : '0;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural unified memory
// (instruction space at 0x000, data space offset to 0x100).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
    logic [1:0]  d_size = '0;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_done, d_err;
    logic [31:0] d_rdata;
    logic        mem_ifetch, mem_read, mem_write, mem_signed;
    logic [1:0]  mem_size;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int excl_viol = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(3), .AW(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_ifetch(mem_ifetch), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Behavioural memory: the memory, not the arbiter, does extension and data offset.
    logic [7:0] mem [0:511];
    logic [8:0] ea;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        ea = {!mem_ifetch, mem_addr};
        b0 = mem[ea];
        b1 = mem[ea + 9'd1];
        b2 = mem[ea + 9'd2];
        b3 = mem[ea + 9'd3];
        case (mem_size)
            2'b00:   mem_rdata = {b3, b2, b1, b0};
            2'b01:   mem_rdata = {{16{mem_signed & b1[7]}}, b1, b0};
            2'b10:   mem_rdata = {{24{mem_signed & b0[7]}}, b0};
            default: mem_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[0]   <= 8'h33;
            mem[256] <= 8'd17;
        end else if (mem_write) begin
            mem[ea] <= mem_wdata[7:0];
            if (mem_size != 2'b10) mem[ea + 9'd1] <= mem_wdata[15:8];
            if (mem_size == 2'b00) begin
                mem[ea + 9'd2] <= mem_wdata[23:16];
                mem[ea + 9'd3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_write) wr_cnt++;
        if (mem_read)  rd_cnt++;
        if (32'(mem_ifetch) + 32'(mem_read) + 32'(mem_write) > 1) excl_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic do_d(input vec_t v, input string name);
        int  rd0, wr0;
        bit  got;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        got = 1'b0;
        d_req = 1'b1; d_we = v.we; d_size = v.size; d_signed = v.sgn;
        d_addr = v.addr; d_wdata = v.wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (d_gnt) got = 1'b1;
        end
        check({name, "_gnt"}, 32'(got), 32'd1);
        d_req = 1'b0;
        tick();
        check({name, "_done"}, 32'(d_done), 32'd1);
        check({name, "_err"}, 32'(d_err), 32'(v.exp_err));
        check({name, "_rdata"}, d_rdata, v.exp_rdata);
        check({name, "_rd_strobes"}, 32'(rd_cnt - rd0), 32'(!v.we && !v.exp_err));
        check({name, "_wr_strobes"}, 32'(wr_cnt - wr0), 32'(v.we && !v.exp_err));
        tick();
    endtask

    initial begin
        bit got_d [8];
        int ng;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 8'd12, 32'h000000A5, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b1, 8'd12, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 8'd12, 32'h0,        32'h000000A5, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 8'd0,  32'h0,        32'd17,       1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 8'd2,  32'h0,        32'h00000000, 1'b1};
        vecs[5]  = '{1'b0, 2'b11, 1'b0, 8'd0,  32'h0,        32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 8'd6,  32'h00001234, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 8'd6,  32'h0,        32'h00001234, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 8'd5,  32'h0000BEEF, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 8'd4,  32'h0,        32'h12340000, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 8'd8,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 8'd10, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 8'd8,  32'h0,        32'h0000BEEF, 1'b0};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 8'd8,  32'h55555555, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 8'd8,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 8'd12, 32'h0,        32'h000000A5, 1'b0};

        tick();
        tick();
        check("reset_outputs", 32'(|{if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_err, d_rdata,
                                   mem_ifetch, mem_read, mem_write, mem_size, mem_signed,
                                   mem_addr, mem_wdata, busy}), 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;
        tick();

        // Single fetch: grant N+1, rvalid N+2, idle N+3.
        if_req = 1'b1; if_addr = 8'd0;
        tick();
        check("if_gnt", 32'(if_gnt), 32'd1);
        check("if_mem_ifetch", 32'(mem_ifetch), 32'd1);
        check("if_busy", 32'(busy), 32'd1);
        if_req = 1'b0;
        tick();
        check("if_rvalid", 32'(if_rvalid), 32'd1);
        check("if_rdata", if_rdata, 32'h00000033);
        check("if_ifetch_off", 32'(mem_ifetch), 32'd0);
        tick();
        check("if_idle", 32'(busy), 32'd0);
        check("if_rvalid_off", 32'(if_rvalid), 32'd0);

        // Simultaneous requests: D first, IF three cycles later.
        if_req = 1'b1; if_addr = 8'd0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0; d_addr = 8'd0;
        tick();
        check("sim_d_gnt", 32'(d_gnt), 32'd1);
        check("sim_if_not_gnt", 32'(if_gnt), 32'd0);
        d_req = 1'b0;
        tick();
        check("sim_d_done", 32'(d_done), 32'd1);
        check("sim_d_rdata", d_rdata, 32'd17);
        tick();
        tick();
        check("sim_if_gnt", 32'(if_gnt), 32'd1);
        if_req = 1'b0;
        tick();
        check("sim_if_rvalid", 32'(if_rvalid), 32'd1);
        check("sim_if_rdata", if_rdata, 32'h00000033);
        tick();

        // Starvation limit: D,D,D,IF repeated while both requests are held.
        if_req = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 8'd0;
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            tick();
            if (d_gnt || if_gnt) begin
                got_d[ng] = d_gnt;
                ng++;
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        check("starve_grant_count", 32'(ng), 32'd8);
        for (int i = 0; i < ng; i++)
            check($sformatf("starve_grant_%0d_is_d", i), 32'(got_d[i]), 32'((i % 4) != 3));
        tick();
        tick();
        tick();

        for (int unsigned i = 0; i < 16; i++) do_d(vecs[i], $sformatf("vec%0d", i));

        // Reset during ACCESS of a store: no write, no response, old data survives.
        begin
            int wr0;
            wr0 = wr_cnt;
            d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 8'd0; d_wdata = 32'h11223344;
            tick();
            check("rst_store_gnt", 32'(d_gnt), 32'd1);
            rst = 1'b1;
            d_req = 1'b0;
            #1;
            check("rst_mem_write_low", 32'(mem_write), 32'd0);
            tick();
            check("rst_outputs", 32'(|{d_done, d_gnt, d_rdata, if_rdata, busy, mem_write}), 32'd0);
            rst = 1'b0;
            tick();
            check("rst_no_done", 32'(d_done), 32'd0);
            check("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
            do_d('{1'b0, 2'b00, 1'b0, 8'd0, 32'h0, 32'd17, 1'b0}, "rst_reload");
        end

        check("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
